// File: rtl/sm3_pkg.sv
// sm3_pkg: SM3 constants, FSM encoding, rotate/permutation helpers and the message padding function.
package sm3_pkg;

    localparam int SM3_BLK_BITS = 512;
    localparam int SM3_LEN_BITS = 64;
    localparam int SM3_MSG_MAX  = 4096;
    localparam int SM3_PAD_MAX  = 4608;

    localparam logic [255:0] SM3_IV =
        256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        RUN  = ST_RUN,
        FIN  = ST_FIN
    } sm3_state_e;

    function automatic logic [31:0] sm3_rol(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [31:0] sm3_p0(input logic [31:0] x);
        return x ^ sm3_rol(x, 5'd9) ^ sm3_rol(x, 5'd17);
    endfunction

    function automatic logic [31:0] sm3_p1(input logic [31:0] x);
        return x ^ sm3_rol(x, 5'd15) ^ sm3_rol(x, 5'd23);
    endfunction

    // Message m is right-aligned and zero above bit bits-1; the padded result is
    // right-aligned too, so the caller keeps the low NUM_BLOCKS*512 bits.
    function automatic logic [SM3_PAD_MAX-1:0] sm3_pad(input logic [SM3_MSG_MAX-1:0] m,
                                                       input int unsigned bits);
        int unsigned k;
        logic [SM3_PAD_MAX-1:0] r;
        k = ((bits + 65 + 511) / 512) * SM3_BLK_BITS - bits - 65;
        r = {{(SM3_PAD_MAX-SM3_MSG_MAX-1){1'b0}}, m, 1'b1};
        r = (r << (k + SM3_LEN_BITS)) | {{(SM3_PAD_MAX-SM3_LEN_BITS){1'b0}}, SM3_LEN_BITS'(bits)};
        return r;
    endfunction

endpackage

// File: rtl/sm3_msg_hash_cf.sv
// sm3_CF: iterative SM3 compression core, one round per cycle; re-arms only after cf_start drops.
module sm3_CF
    import sm3_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cf_start,
    input  logic [255:0] iv,
    input  logic [511:0] block,
    output logic [255:0] hash,
    output logic         cf_end
);

    logic [15:0][31:0] w_q;
    logic [7:0][31:0]  r_q, r_d;
    logic [255:0]      v_q, hash_q;
    logic [5:0]        rnd_q;
    logic              run_q, arm_q, end_q;
    logic [31:0]       a12, tj, ss1, ss2, ff, gg, tt1, tt2, w_new;

    // One SM3 round on {A..H} = r_q[7:0] plus the next expanded message word; w_q[15] is W_j.
    always_comb begin
        a12   = sm3_rol(r_q[7], 5'd12);
        tj    = rnd_q < 6'd16 ? 32'h79cc4519 : 32'h7a879d8a;
        ss1   = sm3_rol(a12 + r_q[3] + sm3_rol(tj, rnd_q[4:0]), 5'd7);
        ss2   = ss1 ^ a12;
        ff    = rnd_q < 6'd16 ? r_q[7] ^ r_q[6] ^ r_q[5]
                              : (r_q[7] & r_q[6]) | (r_q[7] & r_q[5]) | (r_q[6] & r_q[5]);
        gg    = rnd_q < 6'd16 ? r_q[3] ^ r_q[2] ^ r_q[1]
                              : (r_q[3] & r_q[2]) | (~r_q[3] & r_q[1]);
        tt1   = ff + r_q[4] + ss2 + (w_q[15] ^ w_q[11]);
        tt2   = gg + r_q[0] + ss1 + w_q[15];
        r_d   = {tt1, r_q[7], sm3_rol(r_q[6], 5'd9), r_q[5],
                 sm3_p0(tt2), r_q[3], sm3_rol(r_q[2], 5'd19), r_q[1]};
        w_new = sm3_p1(w_q[15] ^ w_q[8] ^ sm3_rol(w_q[2], 5'd15)) ^ sm3_rol(w_q[12], 5'd7) ^ w_q[5];
    end

    // Accept a block on an armed cf_start, run 64 rounds, then pulse cf_end with the feed-forward digest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            arm_q  <= 1'b1;
            end_q  <= 1'b0;
            rnd_q  <= '0;
            r_q    <= '0;
            w_q    <= '0;
            v_q    <= '0;
            hash_q <= '0;
        end else begin
            end_q <= 1'b0;
            if (!cf_start) arm_q <= 1'b1;
            if (!run_q && arm_q && cf_start) begin
                run_q <= 1'b1;
                arm_q <= 1'b0;
                rnd_q <= '0;
                v_q   <= iv;
                r_q   <= iv;
                w_q   <= block;
            end else if (run_q) begin
                r_q   <= r_d;
                w_q   <= {w_q[14:0], w_new};
                rnd_q <= rnd_q + 6'd1;
                if (rnd_q == 6'd63) begin
                    run_q  <= 1'b0;
                    end_q  <= 1'b1;
                    hash_q <= v_q ^ r_d;
                end
            end
        end
    end

    assign hash   = hash_q;
    assign cf_end = end_q;

endmodule

// File: rtl/sm3_msg_hash.sv
// sm3_msg_hash: pads a MSG_BITS-bit message and hashes it block by block through sm3_CF.
// Optional SM3_MSG_HASH_IV_OVERRIDE_EN adds iv_in, sampled as the chaining value at start.
module sm3_msg_hash
    import sm3_pkg::*;
#(
    parameter int MSG_BITS = 920
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MSG_BITS-1:0] msg,
`ifdef SM3_MSG_HASH_IV_OVERRIDE_EN
    input  logic [255:0]        iv_in,
`endif
    output logic                busy,
    output logic                done,
    output logic [255:0]        hash
);

    localparam int NUM_BLOCKS = (MSG_BITS + 65 + 511) / 512;
    localparam int PAD_BITS   = NUM_BLOCKS * SM3_BLK_BITS;
    localparam int CW         = $clog2(NUM_BLOCKS + 1);

    sm3_state_e          state_q, state_d;
    logic [PAD_BITS-1:0] pad_q, pad_d, blk_sh;
    logic [255:0]        iv_q, iv_d, hash_q, hash_d, iv_sel, cf_hash;
    logic [CW-1:0]       blk_q, blk_d;
    logic                cf_start_q, cf_start_d, cf_end;
    logic [511:0]        cf_block;

`ifdef SM3_MSG_HASH_IV_OVERRIDE_EN
    assign iv_sel = iv_in;
`else
    assign iv_sel = SM3_IV;
`endif

    assign blk_sh   = pad_q << {blk_q, 9'd0};
    assign cf_block = blk_sh[PAD_BITS-1 -: SM3_BLK_BITS];

    sm3_CF u_cf (
        .clk      (clk),
        .rst_n    (~reset),
        .cf_start (cf_start_q),
        .iv       (iv_q),
        .block    (cf_block),
        .hash     (cf_hash),
        .cf_end   (cf_end)
    );

    // Sequencer: capture padding at start, feed each block, chain the digest, finish with a done cycle.
    always_comb begin
        state_d    = state_q;
        pad_d      = pad_q;
        iv_d       = iv_q;
        blk_d      = blk_q;
        cf_start_d = cf_start_q;
        hash_d     = hash_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                pad_d   = PAD_BITS'(sm3_pad(SM3_MSG_MAX'(msg), MSG_BITS));
                iv_d    = iv_sel;
                blk_d   = '0;
            end
            LOAD: begin
                cf_start_d = 1'b1;
                state_d    = RUN;
            end
            RUN: if (cf_end) begin
                iv_d       = cf_hash;
                cf_start_d = 1'b0;
                if (blk_q == CW'(NUM_BLOCKS - 1)) begin
                    state_d = FIN;
                    hash_d  = cf_hash;
                end else begin
                    blk_d   = blk_q + CW'(1);
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pad_q      <= '0;
            iv_q       <= SM3_IV;
            blk_q      <= '0;
            cf_start_q <= 1'b0;
            hash_q     <= '0;
        end else begin
            state_q    <= state_d;
            pad_q      <= pad_d;
            iv_q       <= iv_d;
            blk_q      <= blk_d;
            cf_start_q <= cf_start_d;
            hash_q     <= hash_d;
        end
    end

    assign busy = (state_q == LOAD) || (state_q == RUN);
    assign done = state_q == FIN;
    assign hash = hash_q;

endmodule

// File: tb/tb_sm3_msg_hash.sv
// tb_sm3_msg_hash: directed checks of sm3_msg_hash for several message lengths against known digests and a reference SM3.
module tb_sm3_msg_hash;

    localparam logic [255:0] IV   = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
    localparam logic [255:0] ABC  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] ABCD = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
    localparam int BLK_CYC = 67;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   start_v, busy_v, done_v;
    logic [919:0] msg_v [5];
    logic [255:0] hash_v [5];
`ifdef SM3_MSG_HASH_IV_OVERRIDE_EN
    logic [255:0] iv_in;
`endif
    int cyc = 0;
    int done_cnt [5];
    int done_at [5];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sm3_msg_hash #(.MSG_BITS(24)) u0 (
`ifdef SM3_MSG_HASH_IV_OVERRIDE_EN
        .iv_in(iv_in),
`endif
        .clk(clk), .reset(reset), .start(start_v[0]), .msg(msg_v[0][23:0]),
        .busy(busy_v[0]), .done(done_v[0]), .hash(hash_v[0]));
    sm3_msg_hash #(.MSG_BITS(512)) u1 (
`ifdef SM3_MSG_HASH_IV_OVERRIDE_EN
        .iv_in(iv_in),
`endif
        .clk(clk), .reset(reset), .start(start_v[1]), .msg(msg_v[1][511:0]),
        .busy(busy_v[1]), .done(done_v[1]), .hash(hash_v[1]));
    sm3_msg_hash #(.MSG_BITS(447)) u2 (
`ifdef SM3_MSG_HASH_IV_OVERRIDE_EN
        .iv_in(iv_in),
`endif
        .clk(clk), .reset(reset), .start(start_v[2]), .msg(msg_v[2][446:0]),
        .busy(busy_v[2]), .done(done_v[2]), .hash(hash_v[2]));
    sm3_msg_hash #(.MSG_BITS(448)) u3 (
`ifdef SM3_MSG_HASH_IV_OVERRIDE_EN
        .iv_in(iv_in),
`endif
        .clk(clk), .reset(reset), .start(start_v[3]), .msg(msg_v[3][447:0]),
        .busy(busy_v[3]), .done(done_v[3]), .hash(hash_v[3]));
    sm3_msg_hash #(.MSG_BITS(920)) u4 (
`ifdef SM3_MSG_HASH_IV_OVERRIDE_EN
        .iv_in(iv_in),
`endif
        .clk(clk), .reset(reset), .start(start_v[4]), .msg(msg_v[4]),
        .busy(busy_v[4]), .done(done_v[4]), .hash(hash_v[4]));

    always @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (done_v[k]) begin
                done_cnt[k] <= done_cnt[k] + 1;
                done_at[k]  <= cyc;
            end
        end
        cyc <= cyc + 1;
    end

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rl(x, 9) ^ rl(x, 17);
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    function automatic logic [255:0] model(input logic [919:0] m, input int nbits, input logic [255:0] iv);
        logic [1535:0] p;
        logic [31:0] w [68];
        logic [31:0] a, b, c, d, e, f, g, h, tj, ss1, ss2, tt1, tt2;
        logic [255:0] v;
        int nblk;
        nblk = (nbits + 65 + 511) / 512;
        p = '0;
        for (int i = 0; i < nbits; i++) p[nblk*512-1-i] = m[nbits-1-i];
        p[nblk*512-1-nbits] = 1'b1;
        p[63:0] = 64'(nbits);
        v = iv;
        for (int bk = 0; bk < nblk; bk++) begin
            for (int j = 0; j < 16; j++) w[j] = p[nblk*512-1-bk*512-32*j -: 32];
            for (int j = 16; j < 68; j++)
                w[j] = p1(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
            {a, b, c, d, e, f, g, h} = v;
            for (int j = 0; j < 64; j++) begin
                tj  = j < 16 ? 32'h79cc4519 : 32'h7a879d8a;
                ss1 = rl(rl(a, 12) + e + rl(tj, j % 32), 7);
                ss2 = ss1 ^ rl(a, 12);
                tt1 = (j < 16 ? a ^ b ^ c : (a & b) | (a & c) | (b & c)) + d + ss2 + (w[j] ^ w[j+4]);
                tt2 = (j < 16 ? e ^ f ^ g : (e & f) | (~e & g)) + h + ss1 + w[j];
                d = c; c = rl(b, 9); b = a; a = tt1;
                h = g; g = rl(f, 19); f = e; e = p0(tt2);
            end
            v = v ^ {a, b, c, d, e, f, g, h};
        end
        return v;
    endfunction

    function automatic logic [919:0] pat(input logic [31:0] seed, input int nbits);
        logic [919:0] r;
        logic [31:0] x;
        x = seed;
        r = '0;
        for (int i = 0; i < nbits; i++) begin
            x = x * 32'd1664525 + 32'd1013904223;
            r[i] = x[31];
        end
        return r;
    endfunction

    task automatic chk(input logic [255:0] obs, input logic [255:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int k, input int n0);
        for (int w = 0; w < 2000 && done_cnt[k] == n0; w++) @(negedge clk);
    endtask

    task automatic run_chk(input int k, input logic [919:0] m, input int nblk,
                           input logic [255:0] exp, input string tag);
        int t0, n0;
        @(negedge clk);
        msg_v[k] = m;
        start_v[k] = 1'b1;
        t0 = cyc;
        n0 = done_cnt[k];
        @(negedge clk);
        start_v[k] = 1'b0;
        msg_v[k] = ~m;
        chk(256'(busy_v[k]), 256'(1), {tag, "_busy"});
        wait_done(k, n0);
        chk(256'(done_cnt[k] - n0), 256'(1), {tag, "_done"});
        chk(256'(done_at[k] - t0), 256'(1 + nblk * BLK_CYC), {tag, "_lat"});
        chk(hash_v[k], exp, {tag, "_hash"});
        chk(256'(busy_v[k]), 256'(0), {tag, "_idle"});
    endtask

    initial begin
        int t0, n0;
        logic [919:0] abc_m, abcd_m, xyz_m, m4;
        reset = 1'b1;
        start_v = '0;
        for (int k = 0; k < 5; k++) msg_v[k] = '0;
`ifdef SM3_MSG_HASH_IV_OVERRIDE_EN
        iv_in = IV;
`endif
        abc_m = '0;  abc_m[23:0] = 24'h616263;
        xyz_m = '0;  xyz_m[23:0] = 24'h78797a;
        abcd_m = '0; abcd_m[511:0] = {16{32'h61626364}};
        repeat (3) @(negedge clk);
        chk(256'(busy_v[0]), 256'(0), "rst_busy0");
        chk(256'(done_v[0]), 256'(0), "rst_done0");
        chk(hash_v[0], 256'(0), "rst_hash0");
        chk(256'(busy_v[4]), 256'(0), "rst_busy4");
        chk(256'(done_v[4]), 256'(0), "rst_done4");
        chk(hash_v[4], 256'(0), "rst_hash4");
        reset = 1'b0;

        run_chk(0, abc_m, 1, ABC, "abc");
        run_chk(1, abcd_m, 2, ABCD, "abcd16");
        run_chk(2, pat(32'h1234, 447), 1, model(pat(32'h1234, 447), 447, IV), "m447");
        run_chk(3, pat(32'h5678, 448), 2, model(pat(32'h5678, 448), 448, IV), "m448");
        m4 = pat(32'h9abc, 920);
        run_chk(4, m4, 2, model(m4, 920, IV), "m920");

        // second start with a different message while busy
        @(negedge clk);
        msg_v[0] = abc_m; start_v[0] = 1'b1; t0 = cyc; n0 = done_cnt[0];
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        msg_v[0] = xyz_m; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, n0);
        chk(256'(done_at[0] - t0), 256'(1 + BLK_CYC), "ign_lat");
        chk(hash_v[0], ABC, "ign_hash");
        repeat (80) @(negedge clk);
        chk(256'(done_cnt[0] - n0), 256'(1), "ign_single");

        // start held high: next hash begins the cycle after done
        @(negedge clk);
        msg_v[0] = xyz_m; start_v[0] = 1'b1; n0 = done_cnt[0];
        wait_done(0, n0);
        t0 = done_at[0];
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, n0 + 1);
        chk(256'(done_at[0] - t0), 256'(2 + BLK_CYC), "hold_gap");
        chk(hash_v[0], model(xyz_m, 24, IV), "hold_hash");

        // reset during RUN of block 1, with a simultaneous start on an idle instance
        m4 = pat(32'h4242, 920);
        @(negedge clk);
        msg_v[4] = m4; start_v[4] = 1'b1; n0 = done_cnt[4];
        @(negedge clk);
        start_v[4] = 1'b0;
        repeat (98) @(negedge clk);
        reset = 1'b1; start_v[0] = 1'b1;
        @(negedge clk);
        chk(256'(busy_v[4]), 256'(0), "mid_rst_busy");
        chk(256'(done_v[4]), 256'(0), "mid_rst_done");
        chk(hash_v[4], 256'(0), "mid_rst_hash");
        chk(256'(busy_v[0]), 256'(0), "rst_beats_start");
        reset = 1'b0; start_v[0] = 1'b0;
        repeat (150) @(negedge clk);
        chk(256'(done_cnt[4] - n0), 256'(0), "mid_rst_nodone");
        run_chk(4, m4, 2, model(m4, 920, IV), "restart");

`ifdef SM3_MSG_HASH_IV_OVERRIDE_EN
        iv_in = ABC;
        run_chk(0, abc_m, 1, model(abc_m, 24, ABC), "iv_ovr");
        iv_in = IV;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm3_msg_hash.md
# sm3_msg_hash

Parametrised SM3 message hasher: pads a fixed-length message of MSG_BITS bits per GB/T 32905, then runs NUM_BLOCKS compression rounds through the shared SM3 compression core. Used for every fixed-format hash in the Picnic flow, for example seed/aux/salt/index commitments and challenge inputs. Each call site picks its message length through MSG_BITS instead of carrying a hand-padded copy.

## Interface
- MSG_BITS, default 920 — message length in bits; legal range 1..4096.
- NUM_BLOCKS (localparam) — (MSG_BITS + 65 + 511) / 512.
- PAD_BITS (localparam) — NUM_BLOCKS * 512.
- clk  in  1 — single clock; every register updates on the rising edge.
- reset  in  1 — synchronous, active-high.
- start  in  1 — request; sampled only in IDLE.
- msg  in  MSG_BITS — message, MSB = first bit hashed; sampled in the start cycle.
- busy  out  1 — high from the cycle after start is accepted until done.
- done  out  1 — one-cycle pulse; hash is valid in that cycle.
- hash  out  256 — digest; held until the next accepted start.
- iv_in  in  256 — present only under SM3_MSG_HASH_IV_OVERRIDE_EN.

## Operation
- Padding is built combinationally and captured in the start cycle into register pad_q[PAD_BITS-1:0].
  - Layout: {msg, 1'b1, K zero bits, MSG_BITS as 64-bit big-endian}.
  - K = PAD_BITS − MSG_BITS − 65.
- Block b (0 = first) is pad_q[PAD_BITS-1-512*b -: 512].
- FSM states:
  - IDLE → LOAD on start. Capture pad_q and set iv_q to the IV. Set blk_cnt = 0.
  - LOAD → RUN. Drive cf_start = 1 with block blk_cnt and chaining value iv_q.
  - RUN: hold cf_start high until cf_end. On cf_end: iv_q ← core hash, cf_start ← 0, then:
    - if blk_cnt == NUM_BLOCKS−1, go to FIN;
    - otherwise blk_cnt + 1 and go to LOAD.
  - FIN: hash ← iv_q, pulse done, go to IDLE.
- Default IV is the SM3 constant 7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e.
- blk_cnt width is $clog2(NUM_BLOCKS+1).
- The core reset input is active-low and is driven with ~reset.
- A start while busy is ignored. It is neither queued nor allowed to corrupt pad_q.
- start held high continuously begins a new hash in the cycle after done (IDLE samples it again).
- msg may change freely after the start cycle.

## Timing
- Reset values: busy = 0, done = 0, hash = 0, state = IDLE, blk_cnt = 0, iv_q = default IV.
- Let L be the core latency from the cycle cf_start rises to the cycle cf_end is high.
- Start sampled in cycle 0; LOAD in cycle 1.
- Each block costs L + 2 cycles: the LOAD cycle plus L + 1 cycles in RUN, including the cf_end cycle.
- done is high in cycle 1 + NUM_BLOCKS·(L+2). busy falls in the same cycle.
- cf_start is low for at least one cycle between blocks, so the core re-arms.
- Reset asserted mid-hash:
  - the next edge returns the block to IDLE with reset values;
  - no done is issued;
  - the core is reset with it.
- reset and start in the same cycle: reset wins.

## Configuration
- SM3_MSG_HASH_IV_OVERRIDE_EN defined:
  - port iv_in exists and is sampled into iv_q in the start cycle;
  - used for chained or tree hashing of long transcripts, with the caller supplying the prior digest.
  - Padding still encodes MSG_BITS only; the caller is responsible for the total-length semantics.
- Undefined: no iv_in port; iv_q always loads the default IV.

## Structure
- Package sm3_pkg:
  - SM3_IV 256-bit constant;
  - SM3_BLK_BITS = 512;
  - SM3_LEN_BITS = 64;
  - FSM state enum (IDLE, LOAD, RUN, FIN).
- Sub-module: the existing compression core sm3_CF (clk, active-low reset, cf_start, iv, block, hash, cf_end). It is instantiated once, not duplicated.
- The padding generator is a function in sm3_pkg, parametrised by MSG_BITS, not a module.

## Test plan
- MSG_BITS=24, msg=24'h616263 ("abc") → one block; done at cycle 1+(L+2); hash = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
- MSG_BITS=512, msg = "abcd"×16 → two blocks; hash = debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732.
- Boundary: MSG_BITS=447 gives NUM_BLOCKS=1; MSG_BITS=448 gives NUM_BLOCKS=2. Check the done cycle and that the digest matches the golden model.
- Start pulsed mid-hash with a different msg → ignored; digest equals that of the first msg.
- Reset asserted in RUN of block 1 (MSG_BITS=920), then restart → no done before the restart; the restarted digest matches the model; outputs are at reset values the cycle after reset.
- With SM3_MSG_HASH_IV_OVERRIDE_EN, iv_in = digest of "abc", MSG_BITS=24, msg="abc" → hash equals the model compression of padded "abc" from that IV.
